// File: rtl/sys_status_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sys_status_pkg
//  Purpose : Shared constants, segment patterns, converter state encoding
//            and segment-encode helper for the status display path.
//  Rev     : 1.0  initial release
// ============================================================================
package sys_status_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int BCD_BITS   = 16;
   localparam int BIN_BITS   = 14;

   localparam logic [BIN_BITS-1:0] SAT_MAX = 14'd9999;

   // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } conv_state_t;

   // Non-decimal nibbles cannot come out of the converter, but blank them anyway
   function automatic logic [6:0] seg_encode(input logic [3:0] i_digit);
      logic [6:0] w_pat;
      w_pat = SEG_BLANK;
      if (i_digit <= 4'd9) begin
         w_pat = SEG_DIGIT[i_digit];
      end
      return w_pat;
   endfunction

endpackage : sys_status_pkg
`default_nettype wire

// File: rtl/sys_status_display_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module  : bin2bcd_seq
//  Purpose : Sequential double-dabble converter, 14-bit binary to four BCD
//            digits. One result per start; the BCD register is only ever
//            written with a complete result.
//  Rev     : 1.0  initial release
// ============================================================================
import sys_status_pkg::*;

module bin2bcd_seq (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_start,
   input  logic [BIN_BITS-1:0] i_bin,
   output logic [BCD_BITS-1:0] o_bcd,
   output logic                o_done
);

   localparam int          SR_W       = BCD_BITS + BIN_BITS;
   localparam logic [3:0]  SHIFT_LAST = 4'(BIN_BITS - 1);

   conv_state_t            r_state;
   conv_state_t            w_next;
   logic [SR_W-1:0]        r_shift;
   logic [SR_W-1:0]        w_adj;
   logic [3:0]             r_cnt;
   logic [BCD_BITS-1:0]    r_bcd;

   // State register
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode: one LOAD, BIN_BITS shifts, one DONE
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_start) w_next = ST_LOAD;
         ST_LOAD:  w_next = ST_SHIFT;
         ST_SHIFT: if (r_cnt == SHIFT_LAST) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift
   always_comb begin
      w_adj = r_shift;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_shift[BIN_BITS + 4*k +: 4] >= 4'd5) begin
            w_adj[BIN_BITS + 4*k +: 4] = r_shift[BIN_BITS + 4*k +: 4] + 4'd3;
         end
      end
   end

   // Shift register, shift counter and result register
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_bcd   <= '0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               r_shift <= {{BCD_BITS{1'b0}}, i_bin};
               r_cnt   <= '0;
            end
            ST_SHIFT: begin
               r_shift <= {w_adj[SR_W-2:0], 1'b0};
               r_cnt   <= r_cnt + 4'd1;
            end
            ST_DONE: begin
               r_bcd <= r_shift[SR_W-1:BIN_BITS];
            end
            default: ;
         endcase
      end
   end

   assign o_bcd  = r_bcd;
   assign o_done = (r_state == ST_DONE);

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/sys_status_display.sv
`default_nettype none
// ============================================================================
//  Module  : sys_status_display
//  Purpose : Status LEDs and 4-digit multiplexed 7-segment display of the
//            pipeline control state (mode, filter enables, Sobel threshold,
//            threshold-bounds flag).
//  Rev     : 1.0  initial release
// ============================================================================
import sys_status_pkg::*;

module sys_status_display #(
   parameter int SCAN_DIV       = 25_000,
   parameter int BLINK_DIV      = 12_500_000,
   parameter int THRESH_W       = 26,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                i_sysclk,
   input  logic                i_rstn,
   input  logic                i_mode,
   input  logic                i_gaussian_enable,
   input  logic                i_sobel_enable,
   input  logic [THRESH_W-1:0] i_sobel_threshold,
   input  logic                i_thresholdBounds,
   output logic [3:0]          o_led,
   output logic [6:0]          o_seg,
   output logic                o_dp,
   output logic [3:0]          o_an
);

   localparam int         SCAN_W  = $clog2(SCAN_DIV + 1);
   localparam int         BLINK_W = $clog2(BLINK_DIV + 1);
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;
   localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

   // ---------------- threshold capture ----------------
   logic [BIN_BITS-1:0] w_sat;
   logic [BIN_BITS-1:0] r_captured;
   logic                r_busy;
   logic                w_start;
   logic                w_conv_done;
   logic [BCD_BITS-1:0] w_bcd;

   assign w_sat   = (i_sobel_threshold > THRESH_W'(SAT_MAX)) ? SAT_MAX
                                                             : i_sobel_threshold[BIN_BITS-1:0];
   // Only a changed value starts a conversion; changes while busy are picked up once idle
   assign w_start = !r_busy && (w_sat != r_captured);

   // Latch the value being converted and track converter occupancy
   always_ff @(posedge i_sysclk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_captured <= '0;
         r_busy     <= 1'b0;
      end else if (w_start) begin
         r_captured <= w_sat;
         r_busy     <= 1'b1;
      end else if (w_conv_done) begin
         r_busy     <= 1'b0;
      end
   end

   bin2bcd_seq u_bin2bcd (
      .i_clk   (i_sysclk),
      .i_rstn  (i_rstn),
      .i_start (w_start),
      .i_bin   (r_captured),
      .o_bcd   (w_bcd),
      .o_done  (w_conv_done)
   );

   // ---------------- digit scan ----------------
   logic [SCAN_W-1:0] r_scan_cnt;
   logic [1:0]        r_digit_idx;

   // Prescaler and digit index; index advances and wraps at terminal count
   always_ff @(posedge i_sysclk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= '0;
      end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
         r_scan_cnt  <= r_scan_cnt + SCAN_W'(1);
      end
   end

   // ---------------- digit content ----------------
   logic [3:0] w_blank;
   logic [3:0] w_digit;
   logic [6:0] w_pat;
   logic [3:0] w_an_hot;

   // Leading-zero blanking; digit 0 is always shown
   always_comb begin
      w_blank[3] = (w_bcd[15:12] == 4'd0);
      w_blank[2] = w_blank[3] && (w_bcd[11:8] == 4'd0);
      w_blank[1] = w_blank[2] && (w_bcd[7:4]  == 4'd0);
      w_blank[0] = 1'b0;
   end

   // Select the current digit and encode it, blanking in passthrough mode
   always_comb begin
      w_digit = w_bcd[3:0];
      case (r_digit_idx)
         2'd0: w_digit = w_bcd[3:0];
         2'd1: w_digit = w_bcd[7:4];
         2'd2: w_digit = w_bcd[11:8];
         2'd3: w_digit = w_bcd[15:12];
         default: w_digit = w_bcd[3:0];
      endcase
      w_pat    = (!i_mode || w_blank[r_digit_idx]) ? SEG_BLANK : seg_encode(w_digit);
      w_an_hot = 4'b0001 << r_digit_idx;
   end

   logic [6:0] r_seg;
   logic [3:0] r_an;
   logic       r_dp;

   // Anode and segment registers load together so a digit never shows its neighbour's pattern
   always_ff @(posedge i_sysclk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_seg <= SEG_OFF;
         r_an  <= AN_OFF;
         r_dp  <= DP_OFF;
      end else begin
         r_seg <= SEG_ACTIVE_LOW ? ~w_pat    : w_pat;
         r_an  <= SEG_ACTIVE_LOW ? ~w_an_hot : w_an_hot;
         r_dp  <= DP_OFF;
      end
   end

   // ---------------- LEDs ----------------
   logic [2:0]         r_led_lo;
   logic               r_led_blink;
   logic               r_bounds_d;
   logic [BLINK_W-1:0] r_blink_cnt;

   // Enable/mode LEDs follow their inputs with one cycle of latency
   always_ff @(posedge i_sysclk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_led_lo <= '0;
      end else begin
         r_led_lo <= {i_sobel_enable, i_gaussian_enable, i_mode};
      end
   end

   // Bounds LED: lights on the rising edge, then toggles every BLINK_DIV cycles while held
   always_ff @(posedge i_sysclk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_bounds_d  <= 1'b0;
         r_led_blink <= 1'b0;
         r_blink_cnt <= '0;
      end else begin
         r_bounds_d <= i_thresholdBounds;
         if (!i_thresholdBounds) begin
            r_led_blink <= 1'b0;
            r_blink_cnt <= '0;
         end else if (!r_bounds_d) begin
            r_led_blink <= 1'b1;
            r_blink_cnt <= '0;
         end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            r_led_blink <= ~r_led_blink;
            r_blink_cnt <= '0;
         end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
         end
      end
   end

   assign o_led = {r_led_blink, r_led_lo};
   assign o_seg = r_seg;
   assign o_an  = r_an;
   assign o_dp  = r_dp;

endmodule : sys_status_display
`default_nettype wire

// File: tb/tb_sys_status_display.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sys_status_display
//  Purpose : Directed self-checking bench for sys_status_display
//            (SCAN_DIV=4, BLINK_DIV=8, active-low segments).
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sys_status_display;

   localparam int THRESH_W = 26;

   logic                clk = 1'b0;
   logic                rstn;
   logic                mode, gauss, sobel, bounds;
   logic [THRESH_W-1:0] thr;
   logic [3:0]          led;
   logic [6:0]          seg;
   logic                dp;
   logic [3:0]          an;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sys_status_display #(
      .SCAN_DIV       (4),
      .BLINK_DIV      (8),
      .THRESH_W       (THRESH_W),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .i_sysclk          (clk),
      .i_rstn            (rstn),
      .i_mode            (mode),
      .i_gaussian_enable (gauss),
      .i_sobel_enable    (sobel),
      .i_sobel_threshold (thr),
      .i_thresholdBounds (bounds),
      .o_led             (led),
      .o_seg             (seg),
      .o_dp              (dp),
      .o_an              (an)
   );

   localparam logic [6:0] OFF = 7'h7F;

   // Active-low 7-segment codes {g..a}
   function automatic logic [6:0] lo(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return OFF;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Scan a bounded number of cycles and record the pattern seen on each digit
   task automatic read_display(output logic [6:0] d3, output logic [6:0] d2,
                               output logic [6:0] d1, output logic [6:0] d0,
                               output logic [3:0] seen);
      d3 = 'x; d2 = 'x; d1 = 'x; d0 = 'x; seen = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         case (an)
            4'b1110: begin d0 = seg; seen[0] = 1'b1; end
            4'b1101: begin d1 = seg; seen[1] = 1'b1; end
            4'b1011: begin d2 = seg; seen[2] = 1'b1; end
            4'b0111: begin d3 = seg; seen[3] = 1'b1; end
            default: ;
         endcase
      end
   endtask

   task automatic check_display(input string name, input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
      logic [6:0] d3, d2, d1, d0;
      logic [3:0] seen;
      read_display(d3, d2, d1, d0, seen);
      checks++;
      if ({seen, d3, d2, d1, d0} !== {4'hF, e3, e2, e1, e0}) begin
         errors++;
         $display("FAIL %s got seen=%h digits=%h_%h_%h_%h exp seen=f digits=%h_%h_%h_%h",
                  name, seen, d3, d2, d1, d0, e3, e2, e1, e0);
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_an;
      rstn = 1'b0; mode = 1'b0; gauss = 1'b0; sobel = 1'b0; bounds = 1'b0; thr = '0;
      ticks(3);
      checks++;
      if ({an, seg, dp, led} !== {4'hF, OFF, 1'b1, 4'h0}) begin
         errors++;
         $display("FAIL reset_outputs got an=%h seg=%h dp=%b led=%h exp an=f seg=7f dp=1 led=0",
                  an, seg, dp, led);
      end
      rstn = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         tick();
         exp_an = ~(4'b0001 << (((t - 1) / 4) % 4));
         checks++;
         if (an !== exp_an) begin
            errors++;
            $display("FAIL scan_after_reset t=%0d got an=%b exp %b", t, an, exp_an);
         end
      end
   endtask

   task automatic test_convert_57();
      mode = 1'b1; thr = 26'd10;
      ticks(40);
      checks++;
      if (dut.w_bcd !== 16'h0010) begin
         errors++; $display("FAIL bcd_10 got %h exp 0010", dut.w_bcd);
      end
      thr = 26'd57;
      ticks(16);
      checks++;
      if (dut.w_bcd !== 16'h0010) begin
         errors++; $display("FAIL bcd_57_early got %h exp 0010", dut.w_bcd);
      end
      tick();
      checks++;
      if (dut.w_bcd !== 16'h0057) begin
         errors++; $display("FAIL bcd_57_latency got %h exp 0057", dut.w_bcd);
      end
      check_display("display_57", OFF, OFF, lo(5), lo(7));
   endtask

   task automatic test_back_to_back();
      int partial = 0;
      thr = 26'd100;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (n == 2) thr = 26'd99;
         if (dut.w_bcd !== 16'h0057 && dut.w_bcd !== 16'h0100 && dut.w_bcd !== 16'h0099)
            partial++;
         if (n == 16 || n == 17 || n == 33 || n == 34) begin
            logic [15:0] exp;
            exp = (n == 16) ? 16'h0057 : (n == 34) ? 16'h0099 : 16'h0100;
            checks++;
            if (dut.w_bcd !== exp) begin
               errors++; $display("FAIL b2b_bcd n=%0d got %h exp %h", n, dut.w_bcd, exp);
            end
         end
      end
      checks++;
      if (partial != 0) begin
         errors++; $display("FAIL b2b_partial got %0d bad values exp 0", partial);
      end
      check_display("display_99", OFF, OFF, lo(9), lo(9));
   endtask

   task automatic test_saturate_zero();
      thr = 26'd123456;
      ticks(17);
      checks++;
      if (dut.w_bcd !== 16'h9999) begin
         errors++; $display("FAIL bcd_sat got %h exp 9999", dut.w_bcd);
      end
      check_display("display_9999", lo(9), lo(9), lo(9), lo(9));
      thr = 26'd0;
      ticks(17);
      checks++;
      if (dut.w_bcd !== 16'h0000) begin
         errors++; $display("FAIL bcd_zero got %h exp 0000", dut.w_bcd);
      end
      check_display("display_0", OFF, OFF, OFF, lo(0));
   endtask

   task automatic test_leds();
      mode = 1'b1; gauss = 1'b0; sobel = 1'b1;
      tick();
      checks++;
      if (led[2:0] !== 3'b101) begin
         errors++; $display("FAIL led_enables_a got %b exp 101", led[2:0]);
      end
      mode = 1'b0; gauss = 1'b1; sobel = 1'b0;
      tick();
      checks++;
      if (led[2:0] !== 3'b010) begin
         errors++; $display("FAIL led_enables_b got %b exp 010", led[2:0]);
      end
      mode = 1'b1; gauss = 1'b0;
      bounds = 1'b1;
      for (int n = 1; n <= 17; n++) begin
         tick();
         if (n == 1 || n == 8 || n == 9 || n == 16 || n == 17) begin
            logic exp;
            exp = (n == 1 || n == 8 || n == 17);
            checks++;
            if (led[3] !== exp) begin
               errors++; $display("FAIL led_blink n=%0d got %b exp %b", n, led[3], exp);
            end
         end
      end
      bounds = 1'b0;
      tick();
      checks++;
      if (led[3] !== 1'b0) begin
         errors++; $display("FAIL led_bounds_off got %b exp 0", led[3]);
      end
   endtask

   task automatic test_mode_off();
      int lit = 0;
      logic [3:0] seen = '0;
      mode = 1'b0; thr = 26'd42;
      ticks(20);
      for (int i = 0; i < 16; i++) begin
         tick();
         if (seg !== OFF) lit++;
         case (an)
            4'b1110: seen[0] = 1'b1;
            4'b1101: seen[1] = 1'b1;
            4'b1011: seen[2] = 1'b1;
            4'b0111: seen[3] = 1'b1;
            default: ;
         endcase
      end
      checks++;
      if (lit != 0 || seen !== 4'hF) begin
         errors++; $display("FAIL mode_off_blank got lit=%0d seen=%h exp lit=0 seen=f", lit, seen);
      end
      checks++;
      if (led[0] !== 1'b0) begin
         errors++; $display("FAIL mode_off_led got %b exp 0", led[0]);
      end
   endtask

   task automatic test_reset_mid_shift();
      mode = 1'b1; thr = 26'd777;
      ticks(5);
      rstn = 1'b0;
      #1;
      checks++;
      if ({an, dut.w_bcd} !== {4'hF, 16'h0000}) begin
         errors++; $display("FAIL midreset_async got an=%h bcd=%h exp an=f bcd=0000", an, dut.w_bcd);
      end
      ticks(2);
      rstn = 1'b1;
      tick();
      checks++;
      if (dut.w_bcd !== 16'h0000) begin
         errors++; $display("FAIL midreset_hold got %h exp 0000", dut.w_bcd);
      end
      ticks(15);
      checks++;
      if (dut.w_bcd !== 16'h0000) begin
         errors++; $display("FAIL midreset_early got %h exp 0000", dut.w_bcd);
      end
      tick();
      checks++;
      if (dut.w_bcd !== 16'h0777) begin
         errors++; $display("FAIL midreset_reconv got %h exp 0777", dut.w_bcd);
      end
      check_display("display_777", OFF, lo(7), lo(7), lo(7));
   endtask

   initial begin
      test_reset();
      test_convert_57();
      test_back_to_back();
      test_saturate_zero();
      test_leds();
      test_mode_off();
      test_reset_mid_shift();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_sys_status_display
`default_nettype wire
